cache_mem_arbiter: RTL and testbench

CACHE_MEM_ARBITER -- requirements
Module: cache_mem_arbiter

---
 rtl/cache_mem_arbiter_pkg.sv | 36 +++
 rtl/cache_mem_arbiter.sv | 144 ++++++++++++++
 tb/tb_cache_mem_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_mem_arbiter_pkg.sv
// Shared definitions for the cache/memory arbiter.
//   ARB_DATA_W  : default address/data width of every requester and memory bus
//   arb_state_t : transaction FSM state encoding
//   owner_t     : which cache currently owns the memory port
//   pick_owner  : grant selection with round-robin tie-break
package cache_mem_arbiter_pkg;

    localparam int ARB_DATA_W = 64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RSP  = 2'd2,
        ST_DONE = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    // On a tie the requester that was not served last wins.
    function automatic owner_t pick_owner(input logic i_req, input logic d_req,
                                          input owner_t last_served);
        owner_t sel;
        if (i_req && d_req) begin
            sel = (last_served == OWN_I) ? OWN_D : OWN_I;
        end else if (d_req) begin
            sel = OWN_D;
        end else begin
            sel = OWN_I;
        end
        return sel;
    endfunction

endpackage

// File: rtl/cache_mem_arbiter.sv
// Arbitrates one shared memory port between an icache fill path and a dcache
// read/write path. One transaction is outstanding at a time.
//
// Ports
//   clk, rst (async, active-low)
//   icache : i_req, i_addr -> i_rdata, i_rvalid (held until i_rresp), i_busy
//   dcache : d_req, d_we, d_addr, d_wdata, d_wstrb -> d_rdata, d_done (held until d_ack)
//   memory : mem_req_valid/ready + we/addr/wdata/wstrb, mem_rsp_valid/data, mem_rsp_ready
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | no transaction; grant on the next requester seen
// REQ     | mem_req_valid high with latched fields until memory accepts
// RSP     | mem_rsp_ready high, waiting for the memory response
// DONE    | completion flag to the owner, held until the owner acks
module cache_mem_arbiter
    import cache_mem_arbiter_pkg::*;
#(
    parameter int DATA_W = ARB_DATA_W
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  i_req,
    input  logic [DATA_W-1:0]     i_addr,
    output logic [DATA_W-1:0]     i_rdata,
    output logic                  i_rvalid,
    input  logic                  i_rresp,
    output logic                  i_busy,

    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [DATA_W-1:0]     d_addr,
    input  logic [DATA_W-1:0]     d_wdata,
    input  logic [DATA_W/8-1:0]   d_wstrb,
    output logic [DATA_W-1:0]     d_rdata,
    output logic                  d_done,
    input  logic                  d_ack,

    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic                  mem_req_we,
    output logic [DATA_W-1:0]     mem_req_addr,
    output logic [DATA_W-1:0]     mem_req_wdata,
    output logic [DATA_W/8-1:0]   mem_req_wstrb,
    input  logic                  mem_rsp_valid,
    input  logic [DATA_W-1:0]     mem_rsp_data,
    output logic                  mem_rsp_ready
);

    arb_state_t state;
    owner_t     owner;
    owner_t     last_served;
    owner_t     grant;

    assign grant = pick_owner(i_req, d_req, last_served);

    // All outputs are registers updated alongside the state, so they change
    // exactly on the transition into the state that owns them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= ST_IDLE;
            owner         <= OWN_I;
            last_served   <= OWN_I;
            i_rdata       <= '0;
            i_rvalid      <= 1'b0;
            i_busy        <= 1'b0;
            d_rdata       <= '0;
            d_done        <= 1'b0;
            mem_req_valid <= 1'b0;
            mem_req_we    <= 1'b0;
            mem_req_addr  <= '0;
            mem_req_wdata <= '0;
            mem_req_wstrb <= '0;
            mem_rsp_ready <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_req || d_req) begin
                        owner         <= grant;
                        state         <= ST_REQ;
                        mem_req_valid <= 1'b1;
                        if (grant == OWN_D) begin
                            i_busy        <= 1'b0;
                            mem_req_we    <= d_we;
                            mem_req_addr  <= d_addr;
                            mem_req_wdata <= d_wdata;
                            mem_req_wstrb <= d_wstrb;
                        end else begin
                            i_busy        <= 1'b1;
                            mem_req_we    <= 1'b0;
                            mem_req_addr  <= i_addr;
                            mem_req_wdata <= '0;
                            mem_req_wstrb <= '1;
                        end
                    end
                end

                ST_REQ: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        mem_rsp_ready <= 1'b1;
                        state         <= ST_RSP;
                    end
                end

                ST_RSP: begin
                    if (mem_rsp_valid) begin
                        mem_rsp_ready <= 1'b0;
                        state         <= ST_DONE;
                        if (owner == OWN_I) begin
                            i_rdata  <= mem_rsp_data;
                            i_rvalid <= 1'b1;
                        end else begin
                            // write responses carry no data for the dcache
                            if (!mem_req_we) begin
                                d_rdata <= mem_rsp_data;
                            end
                            d_done <= 1'b1;
                        end
                    end
                end

                ST_DONE: begin
                    if (owner == OWN_I && i_rresp) begin
                        i_rvalid    <= 1'b0;
                        i_busy      <= 1'b0;
                        last_served <= OWN_I;
                        state       <= ST_IDLE;
                    end else if (owner == OWN_D && d_ack) begin
                        d_done      <= 1'b0;
                        last_served <= OWN_D;
                        state       <= ST_IDLE;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
module tb_cache_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, i_rresp, i_rvalid, i_busy;
    logic [63:0] i_addr, i_rdata;
    logic        d_req, d_we, d_done, d_ack;
    logic [63:0] d_addr, d_wdata, d_rdata;
    logic [7:0]  d_wstrb;
    logic        mem_req_valid, mem_req_ready, mem_req_we;
    logic [63:0] mem_req_addr, mem_req_wdata;
    logic [7:0]  mem_req_wstrb;
    logic        mem_rsp_valid, mem_rsp_ready;
    logic [63:0] mem_rsp_data;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cache_mem_arbiter #(.DATA_W(64)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_rvalid(i_rvalid),
        .i_rresp(i_rresp), .i_busy(i_busy),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_wstrb(d_wstrb), .d_rdata(d_rdata), .d_done(d_done), .d_ack(d_ack),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
        .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .mem_rsp_ready(mem_rsp_ready)
    );

    typedef struct {
        logic        is_d;
        logic        we;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [7:0]  wstrb;
        logic [63:0] mem_data;
        int          rdy_dly;
        int          rsp_dly;
        int          ack_dly;
        logic        exp_we;
        logic [7:0]  exp_wstrb;
        logic [63:0] exp_rdata;
    } vec_t;

    typedef struct {
        logic        we;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [7:0]  wstrb;
    } mreq_t;

    vec_t        vecs[5];
    mreq_t       req_q[$];
    logic [63:0] data_q[$];

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Single-requester transaction with programmable memory/ack delays.
    task automatic run_txn(input vec_t v);
        mreq_t       er;
        logic [63:0] ed;
        logic        seen;
        if (v.is_d) begin
            d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata; d_wstrb = v.wstrb;
        end else begin
            i_req = 1'b1; i_addr = v.addr;
        end
        req_q.push_back('{v.exp_we, v.addr, v.wdata, v.exp_wstrb});
        data_q.push_back(v.exp_rdata);
        seen = 1'b0;
        for (int k = 0; k < 6 && !seen; k++) begin
            tick();
            seen = mem_req_valid;
        end
        er = req_q.pop_front();
        if (!seen) begin
            check("grant_timeout", 64'd0, 64'd1);
            i_req = 1'b0; d_req = 1'b0;
            void'(data_q.pop_front());
            return;
        end
        // granted: drop the request and scramble the requester inputs
        i_req = 1'b0; d_req = 1'b0;
        d_addr = ~v.addr; d_wdata = ~v.wdata; d_we = ~v.we; d_wstrb = ~v.wstrb; i_addr = ~v.addr;
        check("busy_owner", {63'd0, i_busy}, {63'd0, !v.is_d});
        for (int k = 0; k <= v.rdy_dly; k++) begin
            if (k > 0) tick();
            check("req_valid", {63'd0, mem_req_valid}, 64'd1);
            check("req_we", {63'd0, mem_req_we}, {63'd0, er.we});
            check("req_addr", mem_req_addr, er.addr);
            check("req_wstrb", {56'd0, mem_req_wstrb}, {56'd0, er.wstrb});
            if (er.we) check("req_wdata", mem_req_wdata, er.wdata);
        end
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        check("req_drop", {63'd0, mem_req_valid}, 64'd0);
        check("rsp_ready", {63'd0, mem_rsp_ready}, 64'd1);
        for (int k = 0; k < v.rsp_dly; k++) begin
            tick();
            check("rsp_wait", {63'd0, mem_rsp_ready}, 64'd1);
        end
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = v.mem_data;
        tick();
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = {$urandom, $urandom};
        ed = data_q.pop_front();
        for (int k = 0; k <= v.ack_dly; k++) begin
            if (k > 0) tick();
            check("done_flag", {63'd0, v.is_d ? d_done : i_rvalid}, 64'd1);
            check("rdata", v.is_d ? d_rdata : i_rdata, ed);
            check("rsp_ready_off", {63'd0, mem_rsp_ready}, 64'd0);
        end
        if (v.is_d) d_ack = 1'b1; else i_rresp = 1'b1;
        tick();
        d_ack = 1'b0; i_rresp = 1'b0;
        check("done_clear", {63'd0, v.is_d ? d_done : i_rvalid}, 64'd0);
        check("busy_clear", {63'd0, i_busy}, 64'd0);
        check("idle_valid", {63'd0, mem_req_valid}, 64'd0);
    endtask

    // Finish a granted read that is currently in REQ with zero-delay memory.
    task automatic finish_txn(input logic is_d, input logic [63:0] data);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = data;
        tick();
        mem_rsp_valid = 1'b0;
        check("fin_done", {63'd0, is_d ? d_done : i_rvalid}, 64'd1);
        check("fin_data", is_d ? d_rdata : i_rdata, data);
        if (is_d) d_ack = 1'b1; else i_rresp = 1'b1;
        tick();
        d_ack = 1'b0; i_rresp = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] exp_addr;
        logic        exp_d;

        //            is_d we  addr                   wdata                  wstrb  mem_data               rdy rsp ack exp_we exp_wstrb exp_rdata
        vecs[0] = '{1'b0, 1'b0, 64'h0000_0000_0000_1FC0, 64'h0, 8'h00, 64'hFFFF_0000_1234_ABCD, 0, 1, 0, 1'b0, 8'hFF, 64'hFFFF_0000_1234_ABCD};
        vecs[1] = '{1'b1, 1'b0, 64'h0000_0000_8000_2000, 64'h0, 8'hFF, 64'hA5A5_0000_FFFF_1234, 1, 2, 1, 1'b0, 8'hFF, 64'hA5A5_0000_FFFF_1234};
        vecs[2] = '{1'b1, 1'b1, 64'h0000_0000_8000_1000, 64'h0000_0000_DEAD_BEEF, 8'h0F, 64'h0BAD_0BAD_0BAD_0BAD, 5, 0, 0, 1'b1, 8'h0F, 64'hA5A5_0000_FFFF_1234};
        vecs[3] = '{1'b0, 1'b0, 64'h0000_0000_8000_0080, 64'h0, 8'h00, 64'h0123_4567_89AB_CDEF, 2, 3, 2, 1'b0, 8'hFF, 64'h0123_4567_89AB_CDEF};
        vecs[4] = '{1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 64'h0, 8'hF0, 64'h0, 0, 0, 0, 1'b0, 8'hF0, 64'h0};

        rst = 1'b0;
        i_req = 0; i_addr = 0; i_rresp = 0;
        d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_wstrb = 0; d_ack = 0;
        mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_data = 0;
        tick(); tick();
        check("rst_req_valid", {63'd0, mem_req_valid}, 64'd0);
        check("rst_rsp_ready", {63'd0, mem_rsp_ready}, 64'd0);
        check("rst_flags", {60'd0, i_rvalid, i_busy, d_done, mem_req_we}, 64'd0);
        check("rst_i_rdata", i_rdata, 64'd0);
        check("rst_d_rdata", d_rdata, 64'd0);
        check("rst_req_addr", mem_req_addr, 64'd0);
        rst = 1'b1;
        tick();

        // Minimum latency icache fill
        i_req = 1'b1; i_addr = 64'h0000_0000_8000_0040;
        check("lat_n_valid", {63'd0, mem_req_valid}, 64'd0);
        check("lat_n_busy", {63'd0, i_busy}, 64'd0);
        tick();
        i_req = 1'b0;
        check("lat_n1_valid", {63'd0, mem_req_valid}, 64'd1);
        check("lat_n1_busy", {63'd0, i_busy}, 64'd1);
        check("lat_n1_addr", mem_req_addr, 64'h0000_0000_8000_0040);
        check("lat_n1_wstrb", {56'd0, mem_req_wstrb}, 64'hFF);
        mem_req_ready = 1'b1;
        i_rresp = 1'b1;
        tick();
        mem_req_ready = 1'b0; i_rresp = 1'b0;
        check("lat_n2_valid", {63'd0, mem_req_valid}, 64'd0);
        check("lat_n2_rsp_ready", {63'd0, mem_rsp_ready}, 64'd1);
        check("lat_n2_busy", {63'd0, i_busy}, 64'd1);
        check("lat_n2_rvalid", {63'd0, i_rvalid}, 64'd0);
        mem_rsp_valid = 1'b1; mem_rsp_data = 64'h1122_3344_5566_7788;
        tick();
        mem_rsp_valid = 1'b0;
        check("lat_n3_rvalid", {63'd0, i_rvalid}, 64'd1);
        check("lat_n3_rdata", i_rdata, 64'h1122_3344_5566_7788);
        check("lat_n3_busy", {63'd0, i_busy}, 64'd1);
        i_rresp = 1'b1;
        tick();
        i_rresp = 1'b0;
        check("lat_n4_rvalid", {63'd0, i_rvalid}, 64'd0);
        check("lat_n4_busy", {63'd0, i_busy}, 64'd0);
        tick();

        for (int n = 0; n < 5; n++) begin
            run_txn(vecs[n]);
            tick();
        end

        // Withheld icache ack with a dcache request pending
        i_req = 1'b1; i_addr = 64'h0000_0000_8000_0100;
        tick();
        i_req = 1'b0;
        check("hold_grant", {63'd0, mem_req_valid}, 64'd1);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1; mem_rsp_data = 64'hCAFE_F00D_1234_5678;
        tick();
        mem_rsp_valid = 1'b0;
        d_req = 1'b1; d_we = 1'b0; d_addr = 64'h0000_0000_8000_3000;
        for (int k = 0; k < 5; k++) begin
            check("hold_rvalid", {63'd0, i_rvalid}, 64'd1);
            check("hold_rdata", i_rdata, 64'hCAFE_F00D_1234_5678);
            check("hold_no_grant", {63'd0, mem_req_valid}, 64'd0);
            if (k < 4) tick();
        end
        i_rresp = 1'b1;
        tick();
        i_rresp = 1'b0;
        check("hold_released", {63'd0, i_rvalid}, 64'd0);
        check("hold_idle_gap", {63'd0, mem_req_valid}, 64'd0);
        tick();
        d_req = 1'b0;
        check("hold_d_grant", {63'd0, mem_req_valid}, 64'd1);
        check("hold_d_addr", mem_req_addr, 64'h0000_0000_8000_3000);
        check("hold_d_busy", {63'd0, i_busy}, 64'd0);
        finish_txn(1'b1, 64'h0000_0000_0000_0077);
        tick();

        // Tie at reset release, continuous dual requests alternate D,I,D,I
        rst = 1'b0;
        i_req = 1'b1; i_addr = 64'h0000_0000_1111_0000;
        d_req = 1'b1; d_we = 1'b0; d_addr = 64'h0000_0000_2222_0000;
        tick();
        rst = 1'b1;
        tick();
        for (int t = 0; t < 4; t++) begin
            exp_d    = (t % 2 == 0);
            exp_addr = exp_d ? 64'h0000_0000_2222_0000 : 64'h0000_0000_1111_0000;
            check("arb_valid", {63'd0, mem_req_valid}, 64'd1);
            check("arb_addr", mem_req_addr, exp_addr);
            check("arb_busy", {63'd0, i_busy}, {63'd0, !exp_d});
            finish_txn(exp_d, 64'h100 + 64'(t));
            check("arb_idle_gap", {63'd0, mem_req_valid}, 64'd0);
            if (t == 3) begin
                i_req = 1'b0; d_req = 1'b0;
            end
            tick();
        end

        // Reset while waiting for the response
        i_req = 1'b1; i_addr = 64'h0000_0000_8000_0200;
        tick();
        i_req = 1'b0;
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        check("mid_rsp_ready", {63'd0, mem_rsp_ready}, 64'd1);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_rsp_ready", {63'd0, mem_rsp_ready}, 64'd0);
        check("mid_rst_flags", {61'd0, mem_req_valid, i_busy, i_rvalid}, 64'd0);
        check("mid_rst_i_rdata", i_rdata, 64'd0);
        check("mid_rst_d_rdata", d_rdata, 64'd0);
        check("mid_rst_addr", mem_req_addr, 64'd0);
        tick();
        rst = 1'b1;
        mem_rsp_valid = 1'b1; mem_rsp_data = 64'hDEAD_DEAD_DEAD_DEAD;
        tick();
        mem_rsp_valid = 1'b0;
        check("spur_rvalid", {63'd0, i_rvalid}, 64'd0);
        check("spur_done", {63'd0, d_done}, 64'd0);
        check("spur_i_rdata", i_rdata, 64'd0);
        check("spur_req_valid", {63'd0, mem_req_valid}, 64'd0);
        tick();
        check("spur_stay_idle", {62'd0, mem_req_valid, mem_rsp_ready}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
